// File: rtl/zxv_pkg.sv
// Shared constants for the ZX video serializer: attribute bit fields, colour bit order and colour helper.
package zxv_pkg;

    localparam int unsigned ATTR_INK    = 0;
    localparam int unsigned ATTR_PAPER  = 3;
    localparam int unsigned ATTR_BRIGHT = 6;
    localparam int unsigned ATTR_FLASH  = 7;

    // Colour triplets are packed {G,R,B}
    localparam int unsigned COL_B = 0;
    localparam int unsigned COL_R = 1;
    localparam int unsigned COL_G = 2;

    typedef logic [2:0] colour_t;

    // Ink colour for a set pixel, paper colour otherwise
    function automatic colour_t attr_colour(input logic [7:0] attr, input logic pix);
        return pix ? attr[ATTR_INK +: 3] : attr[ATTR_PAPER +: 3];
    endfunction

endpackage

// File: rtl/zx_video_serializer_if.sv
// Video-memory load, control and RGBI output signals of the ZX video serializer.
interface zx_video_serializer_if
    import zxv_pkg::*;
#(
    parameter int unsigned PIX_W = 8
);
    logic             pix_en;
    logic [PIX_W-1:0] q;
    logic             ld_pix;
    logic             ld_attr;
    logic             load;
    logic             frame;
    logic             port_wr;
    colour_t          d;
    logic             active;
    logic             bl;
    logic             r;
    logic             g;
    logic             b;
    logic             i;
    logic             empty;
    logic             flash;

    modport master (
        output pix_en, q, ld_pix, ld_attr, load, frame, port_wr, d, active, bl,
        input  r, g, b, i, empty, flash
    );

    modport slave (
        input  pix_en, q, ld_pix, ld_attr, load, frame, port_wr, d, active, bl,
        output r, g, b, i, empty, flash
    );

endinterface

// File: rtl/zxv_flash_ctr.sv
// Frame counter and flash phase; only present when ZXV_FLASH_EN is defined.
`ifdef ZXV_FLASH_EN
module zxv_flash_ctr #(
    parameter int unsigned FLASH_HALF = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame,
    output logic flash
);
    localparam int unsigned CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CNT_W-1:0] frame_cnt;

    // Phase flips each time the frame count wraps to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            flash     <= 1'b0;
        end else if (frame) begin
            if (frame_cnt == CNT_W'(FLASH_HALF - 1)) begin
                frame_cnt <= '0;
                flash     <= ~flash;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/zx_video_serializer.sv
// ZX-style pixel/attribute serializer with border colour and blanking.
// Flash support is built only when ZXV_FLASH_EN is defined.
module zx_video_serializer
    import zxv_pkg::*;
#(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned FLASH_HALF = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    zx_video_serializer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(PIX_W + 1);

    logic [PIX_W-1:0] pix_hold;
    logic [PIX_W-1:0] shifter;
    logic [7:0]       attr_hold;
    logic [7:0]       attr_cur;
    logic [CNT_W-1:0] bit_cnt;
    logic             empty;
    colour_t          border;
    logic [3:0]       rgbi;
    logic             flash_phase;
    logic             pix_c;
    colour_t          attr_col_c;
    logic [3:0]       rgbi_c;

    // Holding and border registers load regardless of the pixel enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_hold  <= '0;
            attr_hold <= '0;
            border    <= '0;
        end else begin
            if (bus.ld_pix)  pix_hold  <= bus.q;
            if (bus.ld_attr) attr_hold <= bus.q[7:0];
            if (bus.port_wr) border    <= bus.d;
        end
    end

    // Shifter, bit counter and colour output advance on pixel-enable edges only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter  <= '0;
            attr_cur <= '0;
            bit_cnt  <= CNT_W'(PIX_W);
            empty    <= 1'b1;
            rgbi     <= '0;
        end else if (bus.pix_en) begin
            rgbi <= rgbi_c;
            if (bus.load) begin
                shifter  <= pix_hold;
                attr_cur <= attr_hold;
                bit_cnt  <= '0;
                empty    <= 1'b0;
            end else begin
                shifter <= {shifter[PIX_W-2:0], 1'b0};
                if (bit_cnt != CNT_W'(PIX_W)) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    empty   <= (bit_cnt == CNT_W'(PIX_W - 1));
                end
            end
        end
    end

    // Colour from the pre-shift MSB; blanking beats border beats paper area
    always_comb begin
        pix_c      = shifter[PIX_W-1] ^ (attr_cur[ATTR_FLASH] & flash_phase);
        attr_col_c = attr_colour(attr_cur, pix_c);
        rgbi_c     = '0;
        if (bus.bl) begin
            rgbi_c = '0;
        end else if (!bus.active) begin
            rgbi_c = {border[COL_R], border[COL_G], border[COL_B], 1'b0};
        end else begin
            rgbi_c = {attr_col_c[COL_R], attr_col_c[COL_G], attr_col_c[COL_B],
                      attr_cur[ATTR_BRIGHT]};
        end
    end

`ifdef ZXV_FLASH_EN
    zxv_flash_ctr #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flash_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .frame (bus.frame),
        .flash (flash_phase)
    );
`else
    logic unused_frame;
    assign flash_phase  = 1'b0;
    assign unused_frame = bus.frame;
`endif

    assign bus.r     = rgbi[3];
    assign bus.g     = rgbi[2];
    assign bus.b     = rgbi[1];
    assign bus.i     = rgbi[0];
    assign bus.empty = empty;
    assign bus.flash = flash_phase;

endmodule

// File: tb/tb_zx_video_serializer.sv
// Self-checking bench for zx_video_serializer: directed scenarios plus random traffic against a pixel-list model.
module tb_zx_video_serializer;
    import zxv_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned FH = 16;
`ifdef ZXV_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    zx_video_serializer_if #(.PIX_W(8))  v ();
    zx_video_serializer_if #(.PIX_W(16)) w ();

    zx_video_serializer #(.PIX_W(8), .FLASH_HALF(FH)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (v)
    );

    zx_video_serializer #(.PIX_W(16), .FLASH_HALF(FH)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w)
    );

    // Reference model: the loaded word viewed as a list of pixels indexed by m_k
    logic [7:0]  m_pix_hold, m_attr_hold, m_word, m_attr;
    logic [2:0]  m_border;
    logic [3:0]  m_rgbi;
    int unsigned m_k;
    int unsigned m_frames;

    function automatic logic m_flash();
        return FLASH_ON && (((m_frames / FH) % 2) == 1);
    endfunction

    task automatic model_reset();
        m_pix_hold = '0; m_attr_hold = '0; m_word = '0; m_attr = '0;
        m_border = '0; m_rgbi = '0; m_k = W; m_frames = 0;
    endtask

    task automatic model_edge();
        logic    px;
        colour_t col;
        if (v.pix_en) begin
            if (v.bl) begin
                m_rgbi = 4'b0000;
            end else if (!v.active) begin
                m_rgbi = {m_border[1], m_border[2], m_border[0], 1'b0};
            end else begin
                px = (m_k < W) ? m_word[W-1-m_k] : 1'b0;
                if (m_attr[7] && m_flash()) px = ~px;
                col = px ? m_attr[2:0] : m_attr[5:3];
                m_rgbi = {col[1], col[2], col[0], m_attr[6]};
            end
            if (v.load) begin
                m_word = m_pix_hold; m_attr = m_attr_hold; m_k = 0;
            end else if (m_k < W) begin
                m_k++;
            end
        end
        if (v.ld_pix)  m_pix_hold  = v.q;
        if (v.ld_attr) m_attr_hold = v.q;
        if (v.port_wr) m_border    = v.d;
        if (v.frame)   m_frames++;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rgbi8();
        return {v.r, v.g, v.b, v.i};
    endfunction

    function automatic logic [3:0] rgbi16();
        return {w.r, w.g, w.b, w.i};
    endfunction

    // One clock edge on the 8-bit DUT with full model comparison
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("rgbi", rgbi8(), m_rgbi);
        check("empty", 4'(v.empty), 4'(m_k == W));
        check("flash", 4'(v.flash), 4'(m_flash()));
        v.ld_pix = 1'b0; v.ld_attr = 1'b0; v.load = 1'b0; v.frame = 1'b0; v.port_wr = 1'b0;
    endtask

    task automatic cyc16();
        @(posedge clk);
        #1;
        w.ld_pix = 1'b0; w.ld_attr = 1'b0; w.load = 1'b0;
    endtask

    initial begin
        logic [7:0] seq;
        logic [3:0] exp_px;

        v.pix_en = 0; v.q = '0; v.ld_pix = 0; v.ld_attr = 0; v.load = 0; v.frame = 0;
        v.port_wr = 0; v.d = '0; v.active = 0; v.bl = 0;
        w.pix_en = 0; w.q = '0; w.ld_pix = 0; w.ld_attr = 0; w.load = 0; w.frame = 0;
        w.port_wr = 0; w.d = '0; w.active = 0; w.bl = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst_rgbi", rgbi8(), 4'b0000);
        check("rst_empty", 4'(v.empty), 4'b0001);
        check("rst_flash", 4'(v.flash), 4'b0000);
        rst_n = 1'b1;

        // Reset release: still black until a pixel-enable edge
        cyc();
        check("post_rst_rgbi", rgbi8(), 4'b0000);
        v.pix_en = 1'b1;

        // A5 with white ink on black paper
        v.q = 8'hA5; v.ld_pix = 1'b1; cyc();
        v.q = 8'h07; v.ld_attr = 1'b1; cyc();
        v.active = 1'b1; v.load = 1'b1; cyc();
        seq = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            cyc();
            exp_px = seq[7-k] ? 4'b1110 : 4'b0000;
            check("a5_pixel", rgbi8(), exp_px);
        end
        check("a5_empty", 4'(v.empty), 4'b0001);

        // Simultaneous LOAD and LD_PIX: shifter takes the old FF
        v.q = 8'h0A; v.ld_attr = 1'b1; cyc();
        v.q = 8'hFF; v.ld_pix = 1'b1; cyc();
        v.q = 8'h00; v.ld_pix = 1'b1; v.load = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("same_edge_ink", rgbi8(), 4'b1000);
        end
        v.load = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("next_load_paper", rgbi8(), 4'b0010);
        end

        // Border write and blanking
        v.active = 1'b0; v.d = 3'b010; v.port_wr = 1'b1; cyc();
        cyc();
        check("border_red", rgbi8(), 4'b1000);
        v.bl = 1'b1; cyc();
        check("blank", rgbi8(), 4'b0000);
        v.bl = 1'b0; v.active = 1'b1;

        // Flash phase over 32 frames with attribute 87
        v.q = 8'hFF; v.ld_pix = 1'b1; cyc();
        v.q = 8'h87; v.ld_attr = 1'b1; cyc();
        for (int n = 0; n < 16; n++) begin
            v.frame = 1'b1; cyc();
        end
        check("flash_16", 4'(v.flash), 4'(FLASH_ON));
        v.load = 1'b1; cyc();
        cyc();
        check("flash_inv_px", rgbi8(), FLASH_ON ? 4'b0000 : 4'b1110);
        for (int n = 0; n < 16; n++) begin
            v.frame = 1'b1; cyc();
        end
        check("flash_32", 4'(v.flash), 4'b0000);
        v.load = 1'b1; cyc();
        cyc();
        check("flash_off_px", rgbi8(), 4'b1110);

        // Asynchronous reset mid-shift
        v.load = 1'b1; cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_rgbi", rgbi8(), 4'b0000);
        check("async_rst_empty", 4'(v.empty), 4'b0001);
        #1;
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            v.pix_en  = ($urandom_range(0, 3) != 0);
            v.q       = 8'($urandom);
            v.ld_pix  = ($urandom_range(0, 5) == 0);
            v.ld_attr = ($urandom_range(0, 5) == 0);
            v.load    = ($urandom_range(0, 9) == 0);
            v.frame   = 1'($urandom_range(0, 1));
            v.port_wr = ($urandom_range(0, 15) == 0);
            v.d       = 3'($urandom);
            v.active  = ($urandom_range(0, 7) != 0);
            v.bl      = ($urandom_range(0, 15) == 0);
            cyc();
        end
        v.pix_en = 1'b0;

        // 16-pixel build: 8001 gives ink at both ends
        w.pix_en = 1'b1; w.active = 1'b1;
        w.q = 16'h8001; w.ld_pix = 1'b1; cyc16();
        w.q = 16'h0007; w.ld_attr = 1'b1; cyc16();
        w.load = 1'b1; cyc16();
        check("w16_loaded_empty", 4'(w.empty), 4'b0000);
        for (int k = 0; k < 16; k++) begin
            cyc16();
            exp_px = (k == 0 || k == 15) ? 4'b1110 : 4'b0000;
            check("w16_pixel", rgbi16(), exp_px);
            check("w16_empty", 4'(w.empty), 4'(k == 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
